// File: rtl/hilo_pkg.sv
// Shared definitions for the HI/LO execute unit: op encodings, divider FSM
// states and the default datapath width.
package hilo_pkg;

   localparam int DATALENGTH = 32;
   // Reset is asserted when the reset pin equals this level (active-low).
   localparam bit RESETABLE  = 1'b0;

   typedef enum logic [2:0] {
      HILO_OP_NOP   = 3'd0,
      HILO_OP_MULT  = 3'd1,
      HILO_OP_MULTU = 3'd2,
      HILO_OP_DIV   = 3'd3,
      HILO_OP_DIVU  = 3'd4,
      HILO_OP_MTHI  = 3'd5,
      HILO_OP_MTLO  = 3'd6,
      HILO_OP_MADD  = 3'd7
   } hilo_op_e;

   typedef enum logic [1:0] {
      DIV_IDLE  = 2'd0,
      DIV_SETUP = 2'd1,
      DIV_ITER  = 2'd2,
      DIV_FIX   = 2'd3
   } div_state_e;

endpackage

// File: rtl/hilo_divider.sv
// Iterative restoring divider for DIV/DIVU. Operands are captured on start,
// reduced to magnitudes in SETUP, one quotient bit is produced per ITER cycle
// and FIX presents the sign-corrected quotient/remainder while done is high.
// A zero divisor yields quotient all-ones and remainder = dividend.
module hilo_divider
   import hilo_pkg::*;
#(
   parameter int DATA_W    = DATALENGTH,
   parameter int DIV_ITERS = DATALENGTH
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              start,
   input  logic              is_signed,
   input  logic              flush,
   input  logic [DATA_W-1:0] dividend,
   input  logic [DATA_W-1:0] divisor,
   output logic              busy,
   output logic              done,
   output logic [DATA_W-1:0] quotient,
   output logic [DATA_W-1:0] remainder
);

   localparam int CNT_W = (DIV_ITERS > 1) ? $clog2(DIV_ITERS) : 1;

   div_state_e        state;
   logic [CNT_W-1:0]  iter_cnt;
   logic [DATA_W-1:0] a_raw;
   logic [DATA_W-1:0] b_raw;
   logic [DATA_W-1:0] quot;
   logic [DATA_W-1:0] rem;
   logic [DATA_W-1:0] dvsr;
   logic              sgn_mode;
   logic              neg_q;
   logic              neg_r;
   logic              div_zero;
   logic [DATA_W:0]   shifted;
   logic              sub_ok;

   // Magnitude of a two's-complement value when operating in signed mode.
   function automatic logic [DATA_W-1:0] magnitude(input logic [DATA_W-1:0] v,
                                                   input logic sgn);
      return (sgn && v[DATA_W-1]) ? -v : v;
   endfunction

   assign shifted = {rem, quot[DATA_W-1]};
   assign sub_ok  = (shifted >= {1'b0, dvsr});

   // Divider FSM and shift/subtract datapath; flush abandons the divide.
   always_ff @(posedge clock) begin
      if (reset == RESETABLE) begin
         state    <= DIV_IDLE;
         busy     <= 1'b0;
         iter_cnt <= '0;
         a_raw    <= '0;
         b_raw    <= '0;
         quot     <= '0;
         rem      <= '0;
         dvsr     <= '0;
         sgn_mode <= 1'b0;
         neg_q    <= 1'b0;
         neg_r    <= 1'b0;
         div_zero <= 1'b0;
      end else if (flush) begin
         state <= DIV_IDLE;
         busy  <= 1'b0;
      end else begin
         case (state)
            DIV_IDLE: begin
               if (start) begin
                  a_raw    <= dividend;
                  b_raw    <= divisor;
                  sgn_mode <= is_signed;
                  state    <= DIV_SETUP;
                  busy     <= 1'b1;
               end
            end
            DIV_SETUP: begin
               neg_q    <= sgn_mode & (a_raw[DATA_W-1] ^ b_raw[DATA_W-1]);
               neg_r    <= sgn_mode & a_raw[DATA_W-1];
               div_zero <= (b_raw == '0);
               quot     <= magnitude(a_raw, sgn_mode);
               dvsr     <= magnitude(b_raw, sgn_mode);
               rem      <= '0;
               iter_cnt <= '0;
               state    <= DIV_ITER;
            end
            DIV_ITER: begin
               quot     <= {quot[DATA_W-2:0], sub_ok};
               rem      <= sub_ok ? DATA_W'(shifted - {1'b0, dvsr}) : shifted[DATA_W-1:0];
               iter_cnt <= iter_cnt + 1'b1;
               if (iter_cnt == CNT_W'(DIV_ITERS - 1)) begin
                  state <= DIV_FIX;
               end
            end
            DIV_FIX: begin
               state <= DIV_IDLE;
               busy  <= 1'b0;
            end
            default: begin
               state <= DIV_IDLE;
               busy  <= 1'b0;
            end
         endcase
      end
   end

   assign done      = (state == DIV_FIX);
   assign quotient  = div_zero ? '1    : (neg_q ? -quot : quot);
   assign remainder = div_zero ? a_raw : (neg_r ? -rem  : rem);

endmodule

// File: rtl/hilo_unit.sv
// Execute-stage HI/LO owner: single-cycle MULT/MULTU, MTHI/MTLO writes and an
// iterative DIV/DIVU that stalls the pipeline while in flight.
// Optional feature macro HILO_MADD_EN enables op 7 (MADD, signed accumulate
// into {HI,LO}); without it op 7 behaves as NOP.
module hilo_unit
   import hilo_pkg::*;
#(
   parameter int DATA_W    = DATALENGTH,
   parameter int DIV_ITERS = DATALENGTH
) (
   input  logic              clock,
   input  logic              reset,
   input  logic [2:0]        HiloOpE,
   input  logic              HiloValidE,
   input  logic [DATA_W-1:0] SrcAE,
   input  logic [DATA_W-1:0] SrcBE,
   input  logic              FlushE,
   output logic              hilo_stall,
   output logic              hilo_busy,
   output logic [DATA_W-1:0] HiOut,
   output logic [DATA_W-1:0] LoOut
);

   hilo_op_e                   op;
   logic                       take;
   logic                       do_mult;
   logic                       do_multu;
   logic                       do_div;
   logic                       do_divu;
   logic                       do_mthi;
   logic                       do_mtlo;
`ifdef HILO_MADD_EN
   logic                       do_madd;
`endif
   logic                       div_start;
   logic                       div_done;
   logic [DATA_W-1:0]          div_q;
   logic [DATA_W-1:0]          div_r;
   logic signed [2*DATA_W-1:0] a_sx;
   logic signed [2*DATA_W-1:0] b_sx;
   logic signed [2*DATA_W-1:0] prod_s;
   logic [2*DATA_W-1:0]        a_zx;
   logic [2*DATA_W-1:0]        b_zx;
   logic [2*DATA_W-1:0]        prod_u;

   assign op   = hilo_op_e'(HiloOpE);
   assign take = HiloValidE & ~hilo_busy & ~FlushE;

   // Op decode; these are qualified by take before any state changes.
   always_comb begin
      do_mult  = 1'b0;
      do_multu = 1'b0;
      do_div   = 1'b0;
      do_divu  = 1'b0;
      do_mthi  = 1'b0;
      do_mtlo  = 1'b0;
`ifdef HILO_MADD_EN
      do_madd  = 1'b0;
`endif
      case (op)
         HILO_OP_MULT:  do_mult  = 1'b1;
         HILO_OP_MULTU: do_multu = 1'b1;
         HILO_OP_DIV:   do_div   = 1'b1;
         HILO_OP_DIVU:  do_divu  = 1'b1;
         HILO_OP_MTHI:  do_mthi  = 1'b1;
         HILO_OP_MTLO:  do_mtlo  = 1'b1;
`ifdef HILO_MADD_EN
         HILO_OP_MADD:  do_madd  = 1'b1;
`endif
         default: ;
      endcase
   end

   assign a_sx   = {{DATA_W{SrcAE[DATA_W-1]}}, SrcAE};
   assign b_sx   = {{DATA_W{SrcBE[DATA_W-1]}}, SrcBE};
   assign prod_s = a_sx * b_sx;
   assign a_zx   = {{DATA_W{1'b0}}, SrcAE};
   assign b_zx   = {{DATA_W{1'b0}}, SrcBE};
   assign prod_u = a_zx * b_zx;

   assign div_start  = take & (do_div | do_divu);
   // The issuing cycle stalls too, before the divider has registered busy.
   assign hilo_stall = div_start | hilo_busy;

   hilo_divider #(
      .DATA_W    (DATA_W),
      .DIV_ITERS (DIV_ITERS)
   ) u_div (
      .clock     (clock),
      .reset     (reset),
      .start     (div_start),
      .is_signed (do_div),
      .flush     (FlushE),
      .dividend  (SrcAE),
      .divisor   (SrcBE),
      .busy      (hilo_busy),
      .done      (div_done),
      .quotient  (div_q),
      .remainder (div_r)
   );

   // HI/LO registers: divide results land at the end of FIX unless flushed.
   always_ff @(posedge clock) begin
      if (reset == RESETABLE) begin
         HiOut <= '0;
         LoOut <= '0;
      end else if (div_done && !FlushE) begin
         HiOut <= div_r;
         LoOut <= div_q;
      end else if (take) begin
         if (do_mult) begin
            {HiOut, LoOut} <= prod_s;
         end else if (do_multu) begin
            {HiOut, LoOut} <= prod_u;
         end else if (do_mthi) begin
            HiOut <= SrcAE;
         end else if (do_mtlo) begin
            LoOut <= SrcAE;
         end
`ifdef HILO_MADD_EN
         else if (do_madd) begin
            {HiOut, LoOut} <= {HiOut, LoOut} + prod_s;
         end
`endif
      end
   end

endmodule
